// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hold/flush sequencer for the 5-stage pipeline; ports: hazard sources in, per-stage hold/flush, timeout flag and perf counters out
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MC_TIMEOUT     = 64,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
  input  logic                      id_rs1_used_i,
  input  logic                      id_rs2_used_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_i,
  input  logic                      ex_mem_read_i,
  input  logic                      ex_redirect_i,
  input  logic                      mc_start_i,
  input  logic                      mc_done_i,
  input  logic                      imem_ready_i,
  input  logic                      dmem_req_i,
  input  logic                      dmem_ready_i,
  output logic                      pc_hold_o,
  output logic                      pc_redirect_o,
  output logic                      if_id_hold_o,
  output logic                      if_id_flush_o,
  output logic                      id_ex_hold_o,
  output logic                      id_ex_flush_o,
  output logic                      ex_mem_hold_o,
  output logic                      ex_mem_flush_o,
  output logic                      mem_wb_flush_o,
  output logic                      mc_timeout_o,
  output logic [CNT_WIDTH-1:0]      stall_cnt_o,
  output logic [CNT_WIDTH-1:0]      flush_cnt_o
);
  localparam int MCW = $clog2(MC_TIMEOUT);
  localparam logic [8:0] C_RST = 9'b000101011;
  localparam logic [8:0] C_MS  = 9'b101010101;
  localparam logic [8:0] C_MC  = 9'b101010010;
  localparam logic [8:0] C_RD  = 9'b010101000;
  localparam logic [8:0] C_SH  = 9'b000100000;
  localparam logic [8:0] C_LU  = 9'b101001000;
  localparam logic [8:0] C_IM  = 9'b100100000;
  typedef enum logic [1:0] {RUN, REDIR, MC_WAIT} state_t;
  state_t               r_state, w_state_nx;
  logic [MCW-1:0]       r_mc_cnt;
  logic                 r_done_pend, r_timeout;
  logic [CNT_WIDTH-1:0] r_stall_cnt, r_flush_cnt;
  logic                 w_mem_stall, w_load_use, w_mc, w_mc_exit, w_mc_last, w_mc_hold;
  logic [8:0]           w_ctl;
  assign w_mem_stall = dmem_req_i & ~dmem_ready_i;
  assign w_load_use  = ex_mem_read_i & (ex_rd_i != '0) &
                       ((id_rs1_used_i & (id_rs1_i == ex_rd_i)) | (id_rs2_used_i & (id_rs2_i == ex_rd_i)));
  assign w_mc        = r_state == MC_WAIT;
  assign w_mc_exit   = w_mc & (mc_done_i | r_done_pend) & ~w_mem_stall;
  assign w_mc_last   = r_mc_cnt == MCW'(MC_TIMEOUT - 1);
  assign w_mc_hold   = w_mc & ~w_mc_exit;
  // a redirect on the MC exit cycle is taken and still gets its fetch-shadow cycle
  always_comb begin
    w_ctl      = rst              ? C_RST :
                 w_mem_stall      ? C_MS  :
                 w_mc_hold        ? C_MC  :
                 ex_redirect_i    ? C_RD  :
                 r_state == REDIR ? C_SH  :
                 w_load_use       ? C_LU  :
                 ~imem_ready_i    ? C_IM  : '0;
    w_state_nx = w_mem_stall   ? r_state :
                 w_mc_hold     ? (w_mc_last ? RUN : MC_WAIT) :
                 ex_redirect_i ? REDIR :
                 (mc_start_i && r_state == RUN) ? MC_WAIT : RUN;
  end
  assign {pc_hold_o, pc_redirect_o, if_id_hold_o, if_id_flush_o, id_ex_hold_o,
          id_ex_flush_o, ex_mem_hold_o, ex_mem_flush_o, mem_wb_flush_o} = w_ctl;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_mc_cnt    <= '0;
      r_done_pend <= 1'b0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_mc_cnt    <= !w_mc ? '0 : w_mc_last ? r_mc_cnt : r_mc_cnt + 1'b1;
      r_done_pend <= (w_state_nx == MC_WAIT) & (r_done_pend | (mc_done_i & w_mem_stall));
      r_timeout   <= r_timeout | (w_mc_hold & ~w_mem_stall & w_mc_last);
      r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(pc_hold_o & ~&r_stall_cnt);
      r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(pc_redirect_o & ~&r_flush_cnt);
    end
  end
  assign mc_timeout_o = r_timeout;
  assign stall_cnt_o  = r_stall_cnt;
  assign flush_cnt_o  = r_flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  localparam logic [8:0] RST  = 9'b000101011;
  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] LU   = 9'b101001000;
  localparam logic [8:0] RD   = 9'b010101000;
  localparam logic [8:0] SH   = 9'b000100000;
  localparam logic [8:0] MC   = 9'b101010010;
  localparam logic [8:0] MS   = 9'b101010101;
  localparam logic [8:0] IM   = 9'b100100000;
  typedef struct {string tag; logic [8:0] exp;} ent_t;
  logic clk = 1'b0, rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_used, id_rs2_used, ex_mem_read, ex_redirect, mc_start, mc_done;
  logic imem_ready, dmem_req, dmem_ready;
  logic pc_hold, pc_redirect, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush;
  logic ex_mem_hold, ex_mem_flush, mem_wb_flush, mc_timeout;
  logic [31:0] stall_cnt, flush_cnt;
  logic [8:0] ctl;
  ent_t q[$];
  int checks = 0, failures = 0;
  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used), .ex_rd_i(ex_rd),
    .ex_mem_read_i(ex_mem_read), .ex_redirect_i(ex_redirect), .mc_start_i(mc_start),
    .mc_done_i(mc_done), .imem_ready_i(imem_ready), .dmem_req_i(dmem_req),
    .dmem_ready_i(dmem_ready), .pc_hold_o(pc_hold), .pc_redirect_o(pc_redirect),
    .if_id_hold_o(if_id_hold), .if_id_flush_o(if_id_flush), .id_ex_hold_o(id_ex_hold),
    .id_ex_flush_o(id_ex_flush), .ex_mem_hold_o(ex_mem_hold), .ex_mem_flush_o(ex_mem_flush),
    .mem_wb_flush_o(mem_wb_flush), .mc_timeout_o(mc_timeout), .stall_cnt_o(stall_cnt),
    .flush_cnt_o(flush_cnt)
  );
  assign ctl = {pc_hold, pc_redirect, if_id_hold, if_id_flush, id_ex_hold,
                id_ex_flush, ex_mem_hold, ex_mem_flush, mem_wb_flush};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
    end
  endtask
  always @(negedge clk) begin
    ent_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.tag, 32'(ctl), 32'(e.exp));
    end
  end
  task automatic cyc(input string tag, input logic [8:0] e);
    q.push_back('{tag: tag, exp: e});
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_mem_read = 0; ex_redirect = 0; mc_start = 0; mc_done = 0;
    imem_ready = 1; dmem_req = 0; dmem_ready = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1; idle();
    @(posedge clk); #1;
    cyc("rst0", RST); cyc("rst1", RST);
    rst = 0;
    cyc("run", NONE);
    chk("stall0", stall_cnt, 0); chk("flush0", flush_cnt, 0); chk("tmo0", 32'(mc_timeout), 0);
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;
    cyc("lu_rs1", LU);
    idle(); cyc("lu_after", NONE);
    chk("stall_lu", stall_cnt, 1);
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_rs1_used = 1;
    cyc("lu_x0", NONE);
    ex_rd = 5; id_rs1 = 5; id_rs1_used = 0; id_rs2 = 5; id_rs2_used = 0;
    cyc("lu_unused", NONE);
    chk("stall_nolu", stall_cnt, 1);
    id_rs1 = 3; id_rs2_used = 1;
    cyc("lu_rs2", LU);
    idle(); cyc("idle", NONE);
    chk("stall_rs2", stall_cnt, 2);
    ex_redirect = 1; cyc("redir", RD);
    ex_redirect = 0; cyc("shadow", SH);
    cyc("redir_run", NONE);
    chk("flush1", flush_cnt, 1);
    ex_redirect = 1; ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; id_rs1_used = 1; imem_ready = 0;
    cyc("redir_mask", RD);
    ex_redirect = 0; cyc("shadow_mask", SH);
    idle(); cyc("run2", NONE);
    chk("flush2", flush_cnt, 2); chk("stall_redir", stall_cnt, 2);
    imem_ready = 0; cyc("imem", IM);
    idle(); cyc("imem_ok", NONE);
    chk("stall_im", stall_cnt, 3);
    mc_start = 1; cyc("mc_start", NONE);
    mc_start = 0;
    for (int i = 0; i < 3; i++) cyc("mc_wait", MC);
    mc_done = 1; cyc("mc_done", NONE);
    mc_done = 0; cyc("mc_run", NONE);
    chk("stall_mc", stall_cnt, 6);
    mc_start = 1; cyc("ms_start", NONE);
    mc_start = 0; dmem_req = 1;
    cyc("ms1", MS);
    mc_done = 1; cyc("ms2", MS);
    mc_done = 0; cyc("ms3", MS);
    dmem_req = 0; cyc("ms_pend_rel", NONE);
    cyc("ms_run", NONE);
    mc_start = 1; cyc("pc_start", NONE);
    mc_start = 0; cyc("pend_clr", MC);
    mc_done = 1; cyc("pend_done", NONE);
    mc_done = 0;
    chk("stall_ms", stall_cnt, 10);
    mc_start = 1; cyc("mr_start", NONE);
    mc_start = 0; ex_redirect = 1; dmem_req = 1;
    cyc("mr1", MS);
    mc_done = 1; cyc("mr2", MS);
    mc_done = 0; cyc("mr3", MS);
    dmem_req = 0; cyc("mr_redir", RD);
    ex_redirect = 0; cyc("mr_shadow", SH);
    cyc("mr_run", NONE);
    chk("stall_mr", stall_cnt, 13); chk("flush3", flush_cnt, 3);
    mc_start = 1; cyc("to_start", NONE);
    mc_start = 0;
    for (int i = 0; i < 63; i++) cyc("to_wait", MC);
    chk("tmo_early", 32'(mc_timeout), 0);
    cyc("to_last", MC);
    chk("tmo_set", 32'(mc_timeout), 1);
    cyc("to_rel", NONE); cyc("to_run", NONE);
    chk("tmo_sticky", 32'(mc_timeout), 1); chk("stall_to", stall_cnt, 77);
    mc_start = 1; cyc("rm_start", NONE);
    mc_start = 0; cyc("rm_wait", MC);
    rst = 1; dmem_req = 1;
    cyc("rm_rst0", RST); cyc("rm_rst1", RST);
    rst = 0; dmem_req = 0;
    cyc("rm_run", NONE);
    chk("rst_stall", stall_cnt, 0); chk("rst_flush", flush_cnt, 0); chk("rst_tmo", 32'(mc_timeout), 0);
    ex_redirect = 1; cyc("rr_redir", RD);
    ex_redirect = 0; rst = 1; cyc("rr_rst", RST);
    rst = 0; cyc("rr_run", NONE);
    chk("rr_flush", flush_cnt, 0);
    chk("queue_empty", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
